// File: rtl/delayed_forward_unit_if.sv
// Bundle, regfile-read, forwarding and result signals of delayed_forward_unit.
// Both in_* and out_* transfer on a rising edge where valid && ready; a valid side holds its payload until then.
interface delayed_forward_unit_if #(
  parameter int LANES  = 2,
  parameter int STAGES = 3,
  parameter int DATA_W = 32,
  parameter int AW     = 5
);
  logic                         flush;
  logic                         in_valid;
  logic                         in_ready;
  logic [LANES-1:0]             in_lane_valid;
  logic [LANES*32-1:0]          in_pc;
  logic [LANES*AW-1:0]          in_rs1;
  logic [LANES*AW-1:0]          in_rs2;
  logic [LANES-1:0]             in_use_imm;
  logic [LANES*DATA_W-1:0]      in_imm;
  logic [LANES*3-1:0]           in_br_op;
  logic [LANES*16-1:0]          in_br_off;
  logic [2*LANES*AW-1:0]        reg_raddr;
  logic [2*LANES*DATA_W-1:0]    reg_rdata;
  logic [STAGES*LANES-1:0]      fwd_valid;
  logic [STAGES*LANES*AW-1:0]   fwd_rd;
  logic [STAGES*LANES*DATA_W-1:0] fwd_data;
  logic [STAGES*LANES-1:0]      fwd_ready;
  logic                         out_valid;
  logic                         out_ready;
  logic [LANES-1:0]             out_lane_valid;
  logic [LANES*DATA_W-1:0]      out_opa;
  logic [LANES*DATA_W-1:0]      out_opb;
  logic [LANES-1:0]             out_br_taken;
  logic [LANES*32-1:0]          out_br_target;
  logic [15:0]                  stall_cnt;
  logic [1:0]                   dbg_state;

  modport slave (
    input  flush, in_valid, in_lane_valid, in_pc, in_rs1, in_rs2, in_use_imm, in_imm,
           in_br_op, in_br_off, reg_rdata, fwd_valid, fwd_rd, fwd_data, fwd_ready, out_ready,
    output in_ready, reg_raddr, out_valid, out_lane_valid, out_opa, out_opb, out_br_taken,
           out_br_target, stall_cnt, dbg_state
  );

  modport master (
    output flush, in_valid, in_lane_valid, in_pc, in_rs1, in_rs2, in_use_imm, in_imm,
           in_br_op, in_br_off, reg_rdata, fwd_valid, fwd_rd, fwd_data, fwd_ready, out_ready,
    input  in_ready, reg_raddr, out_valid, out_lane_valid, out_opa, out_opb, out_br_taken,
           out_br_target, stall_cnt, dbg_state
  );
endinterface

// File: rtl/delayed_forward_unit.sv
// Latches an issue bundle, resolves operands through multi-stage forwarding
// (stalling on not-yet-final producers), evaluates branches and hands results out.
module delayed_forward_unit #(
  parameter int LANES  = 2,
  parameter int STAGES = 3,
  parameter int DATA_W = 32,
  parameter int AW     = 5
) (
  input logic                  clk,
  input logic                  rst_n,
  delayed_forward_unit_if.slave bus
);
  typedef enum logic [1:0] {S_EMPTY = 2'd0, S_RESOLVE = 2'd1, S_OUT = 2'd2} state_t;

  state_t                  r_state, w_next;
  logic                    w_in_ready, w_accept, w_hazard;
  logic [LANES-1:0]        r_lane_valid, r_use_imm;
  logic [LANES*32-1:0]     r_pc;
  logic [LANES*AW-1:0]     r_rs1, r_rs2;
  logic [LANES*DATA_W-1:0] r_imm;
  logic [LANES*3-1:0]      r_br_op;
  logic [LANES*16-1:0]     r_br_off;
  logic [DATA_W-1:0]       w_opa [LANES];
  logic [DATA_W-1:0]       w_opb [LANES];
  logic [LANES-1:0]        w_taken;
  logic [LANES*32-1:0]     w_target;
  logic [LANES-1:0]        r_out_lane_valid, r_out_taken;
  logic [LANES*DATA_W-1:0] r_out_opa, r_out_opb;
  logic [LANES*32-1:0]     r_out_target;
  logic [15:0]             r_stall_cnt;

  for (genvar l = 0; l < LANES; l++) begin : g_raddr
    assign bus.reg_raddr[(2*l)*AW +: AW]   = r_rs1[l*AW +: AW];
    assign bus.reg_raddr[(2*l+1)*AW +: AW] = r_rs2[l*AW +: AW];
  end

  // Later matches overwrite earlier ones, so the scan order encodes the priority.
  always_comb begin : resolve
    logic [AW-1:0]     addr;
    logic [DATA_W-1:0] val, cmp_b;
    logic              rdy, eq, sign;
    logic [2:0]        op;
    logic [15:0]       off;
    addr = '0; val = '0; cmp_b = '0; rdy = 1'b1; eq = 1'b0; sign = 1'b0; op = '0; off = '0;
    w_hazard = 1'b0;
    w_taken  = '0;
    w_target = '0;
    for (int l = 0; l < LANES; l++) begin
      w_opa[l] = '0;
      w_opb[l] = '0;
    end
    for (int l = 0; l < LANES; l++) begin
      for (int s = 0; s < 2; s++) begin
        addr = (s == 0) ? r_rs1[l*AW +: AW] : r_rs2[l*AW +: AW];
        val  = bus.reg_rdata[(2*l+s)*DATA_W +: DATA_W];
        rdy  = 1'b1;
        for (int st = STAGES-1; st >= 0; st--) begin
          for (int fl = 0; fl < LANES; fl++) begin
            if (bus.fwd_valid[st*LANES+fl] && (bus.fwd_rd[(st*LANES+fl)*AW +: AW] == addr)) begin
              val = bus.fwd_data[(st*LANES+fl)*DATA_W +: DATA_W];
              rdy = bus.fwd_ready[st*LANES+fl];
            end
          end
        end
        if (addr == '0) begin
          val = '0;
          rdy = 1'b1;
        end
        if ((s == 1) && r_use_imm[l]) begin
          val = r_imm[l*DATA_W +: DATA_W];
          rdy = 1'b1;
        end
        if (r_lane_valid[l] && !rdy) w_hazard = 1'b1;
        if (s == 0) w_opa[l] = val;
        else        w_opb[l] = val;
      end
      op    = r_br_op[l*3 +: 3];
      off   = r_br_off[l*16 +: 16];
      cmp_b = ((op == 3'd3) || (op == 3'd4)) ? '0 : w_opb[l];
      eq    = (w_opa[l] == cmp_b);
      sign  = w_opa[l][DATA_W-1];
      case (op)
        3'd1:    w_taken[l] = eq;
        3'd2:    w_taken[l] = !eq;
        3'd3:    w_taken[l] = sign | eq;
        3'd4:    w_taken[l] = !(sign | eq);
        3'd5:    w_taken[l] = sign;
        3'd6:    w_taken[l] = !sign;
        default: w_taken[l] = 1'b0;
      endcase
      if ((op != 3'd0) && (op != 3'd7))
        w_target[l*32 +: 32] = r_pc[l*32 +: 32] + 32'd4 + {{14{off[15]}}, off, 2'b00};
    end
  end

  always_comb begin : fsm_next
    w_next     = r_state;
    w_in_ready = 1'b0;
    case (r_state)
      S_EMPTY: begin
        w_in_ready = 1'b1;
        if (bus.in_valid) w_next = S_RESOLVE;
      end
      S_RESOLVE: if (!w_hazard) w_next = S_OUT;
      S_OUT: begin
        w_in_ready = bus.out_ready;
        if (bus.out_ready) w_next = bus.in_valid ? S_RESOLVE : S_EMPTY;
      end
      default: w_next = S_EMPTY;
    endcase
    if (bus.flush) begin
      w_next     = S_EMPTY;
      w_in_ready = 1'b0;
    end
  end

  assign w_accept = bus.in_valid && w_in_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state          <= S_EMPTY;
      r_lane_valid     <= '0;
      r_use_imm        <= '0;
      r_pc             <= '0;
      r_rs1            <= '0;
      r_rs2            <= '0;
      r_imm            <= '0;
      r_br_op          <= '0;
      r_br_off         <= '0;
      r_out_lane_valid <= '0;
      r_out_taken      <= '0;
      r_out_opa        <= '0;
      r_out_opb        <= '0;
      r_out_target     <= '0;
      r_stall_cnt      <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_lane_valid <= bus.in_lane_valid;
        r_use_imm    <= bus.in_use_imm;
        r_pc         <= bus.in_pc;
        r_rs1        <= bus.in_rs1;
        r_rs2        <= bus.in_rs2;
        r_imm        <= bus.in_imm;
        r_br_op      <= bus.in_br_op;
        r_br_off     <= bus.in_br_off;
      end
      if ((r_state == S_RESOLVE) && !bus.flush) begin
        if (w_hazard) begin
          if (r_stall_cnt != 16'hFFFF) r_stall_cnt <= r_stall_cnt + 16'd1;
        end else begin
          r_out_lane_valid <= r_lane_valid;
          r_out_taken      <= w_taken;
          r_out_target     <= w_target;
          for (int l = 0; l < LANES; l++) begin
            r_out_opa[l*DATA_W +: DATA_W] <= w_opa[l];
            r_out_opb[l*DATA_W +: DATA_W] <= w_opb[l];
          end
        end
      end
    end
  end

  assign bus.in_ready       = w_in_ready;
  assign bus.out_valid      = (r_state == S_OUT);
  assign bus.out_lane_valid = r_out_lane_valid;
  assign bus.out_opa        = r_out_opa;
  assign bus.out_opb        = r_out_opb;
  assign bus.out_br_taken   = r_out_taken;
  assign bus.out_br_target  = r_out_target;
  assign bus.stall_cnt      = r_stall_cnt;
  assign bus.dbg_state      = r_state;
endmodule

// File: tb/tb_delayed_forward_unit.sv
// Self-checking bench for delayed_forward_unit: regfile model, forwarding driver,
// expected-result queue popped on each output handshake.
module tb_delayed_forward_unit;
  localparam int LANES = 2, STAGES = 3, DW = 32, AW = 5;
  localparam int EW = LANES + 2*LANES*DW + LANES + LANES*32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  delayed_forward_unit_if #(.LANES(LANES), .STAGES(STAGES), .DATA_W(DW), .AW(AW)) bus ();
  delayed_forward_unit #(.LANES(LANES), .STAGES(STAGES), .DATA_W(DW), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  logic [31:0]   rf [32];
  logic [EW-1:0] exp_q [$];
  logic [EW-1:0] exp_e;
  int n_checks = 0, n_pass = 0, cyc = 0, acc_cyc = 0, exp_stall = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    bus.reg_rdata = '0;
    for (int k = 0; k < 2*LANES; k++) bus.reg_rdata[k*DW +: DW] = rf[bus.reg_raddr[k*AW +: AW]];
  end

  // Reference: youngest stage first, highest lane first, first hit wins.
  function automatic logic [DW-1:0] m_operand(input logic [AW-1:0] a);
    if (a == 0) return '0;
    for (int st = 0; st < STAGES; st++)
      for (int ln = LANES-1; ln >= 0; ln--)
        if (bus.fwd_valid[st*LANES+ln] && bus.fwd_rd[(st*LANES+ln)*AW +: AW] == a)
          return bus.fwd_data[(st*LANES+ln)*DW +: DW];
    return rf[a];
  endfunction

  function automatic logic [EW-1:0] m_bundle();
    logic [LANES*DW-1:0] opa, opb;
    logic [LANES-1:0]    tk;
    logic [LANES*32-1:0] tg;
    logic [DW-1:0]       a, b;
    logic [2:0]          op;
    logic [15:0]         off;
    opa = '0; opb = '0; tk = '0; tg = '0;
    for (int l = 0; l < LANES; l++) begin
      a   = m_operand(bus.in_rs1[l*AW +: AW]);
      b   = bus.in_use_imm[l] ? bus.in_imm[l*DW +: DW] : m_operand(bus.in_rs2[l*AW +: AW]);
      op  = bus.in_br_op[l*3 +: 3];
      off = bus.in_br_off[l*16 +: 16];
      opa[l*DW +: DW] = a;
      opb[l*DW +: DW] = b;
      case (op)
        3'd1: tk[l] = (a == b);
        3'd2: tk[l] = (a != b);
        3'd3: tk[l] = ($signed(a) <= 0);
        3'd4: tk[l] = ($signed(a) > 0);
        3'd5: tk[l] = ($signed(a) < 0);
        3'd6: tk[l] = ($signed(a) >= 0);
        default: tk[l] = 1'b0;
      endcase
      if (op >= 3'd1 && op <= 3'd6)
        tg[l*32 +: 32] = bus.in_pc[l*32 +: 32] + 32'd4 + ({{16{off[15]}}, off} << 2);
    end
    return {bus.in_lane_valid, opa, opb, tk, tg};
  endfunction

  function automatic logic [EW-1:0] obs();
    return {bus.out_lane_valid, bus.out_opa, bus.out_opb, bus.out_br_taken, bus.out_br_target};
  endfunction

  // Scoreboard: every output handshake pops one expected bundle.
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready && !bus.flush) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL scoreboard: unexpected output %h, none expected", obs());
      end else begin
        exp_e = exp_q.pop_front();
        if (obs() !== exp_e) $display("FAIL scoreboard: got %h want %h", obs(), exp_e);
        else n_pass++;
      end
    end
  end

  task automatic clear_inputs();
    bus.flush = 1'b0; bus.in_valid = 1'b0; bus.in_lane_valid = '0; bus.in_pc = '0;
    bus.in_rs1 = '0; bus.in_rs2 = '0; bus.in_use_imm = '0; bus.in_imm = '0;
    bus.in_br_op = '0; bus.in_br_off = '0;
    bus.fwd_valid = '0; bus.fwd_rd = '0; bus.fwd_data = '0; bus.fwd_ready = '0;
  endtask

  task automatic set_lane(input int l, input logic lv, input logic [31:0] pc, input logic [4:0] rs1,
                          input logic [4:0] rs2, input logic ui, input logic [31:0] imm,
                          input logic [2:0] op, input logic [15:0] off);
    bus.in_lane_valid[l] = lv; bus.in_pc[l*32 +: 32] = pc;
    bus.in_rs1[l*AW +: AW] = rs1; bus.in_rs2[l*AW +: AW] = rs2;
    bus.in_use_imm[l] = ui; bus.in_imm[l*DW +: DW] = imm;
    bus.in_br_op[l*3 +: 3] = op; bus.in_br_off[l*16 +: 16] = off;
  endtask

  task automatic set_fwd(input int st, input int ln, input logic [4:0] rd, input logic [31:0] d, input logic rdy);
    bus.fwd_valid[st*LANES+ln] = 1'b1;
    bus.fwd_rd[(st*LANES+ln)*AW +: AW] = rd;
    bus.fwd_data[(st*LANES+ln)*DW +: DW] = d;
    bus.fwd_ready[st*LANES+ln] = rdy;
  endtask

  task automatic send();
    bus.in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.in_ready) break;
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    acc_cyc = cyc;
  endtask

  task automatic wait_valid();
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bus.out_valid) break;
    end
  endtask

  task automatic test_reset();
    clear_inputs();
    bus.out_ready = 1'b1;
    for (int k = 0; k < 32; k++) rf[k] = $urandom;
    rf[0] = 32'hDEADBEEF;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); else n_pass++;
    n_checks++; if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); else n_pass++;
    n_checks++; if (obs() !== '0) $display("FAIL reset_outputs: got %h want 0", obs()); else n_pass++;
    n_checks++; if (bus.stall_cnt !== 16'd0) $display("FAIL reset_stall_cnt: got %0d want 0", bus.stall_cnt); else n_pass++;
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_stall = 0;
  endtask

  task automatic test_r0_fwd();
    @(posedge clk); #1;
    clear_inputs();
    rf[3] = 32'h10;
    set_lane(0, 1'b1, 32'h100, 5'd0, 5'd3, 1'b0, 32'h0, 3'd0, 16'h0);
    set_lane(1, 1'b0, 32'h104, 5'd9, 5'd0, 1'b0, 32'h0, 3'd0, 16'h0);
    set_fwd(0, 0, 5'd0, 32'h55, 1'b1);
    set_fwd(1, 1, 5'd0, 32'h66, 1'b0);
    set_fwd(2, 0, 5'd9, 32'h77, 1'b0);
    exp_q.push_back(m_bundle());
    send();
    wait_valid();
    n_checks++; if (cyc - acc_cyc != 1) $display("FAIL r0_latency: got %0d want 1", cyc - acc_cyc); else n_pass++;
    n_checks++; if (bus.out_opa[31:0] !== 32'h0) $display("FAIL r0_opa: got %h want 0", bus.out_opa[31:0]); else n_pass++;
    n_checks++; if (bus.out_opb[31:0] !== 32'h10) $display("FAIL r0_opb: got %h want 10", bus.out_opb[31:0]); else n_pass++;
  endtask

  task automatic test_priority();
    @(posedge clk); #1;
    clear_inputs();
    rf[5] = 32'h99;
    set_lane(0, 1'b1, 32'h200, 5'd5, 5'd0, 1'b0, 32'h0, 3'd0, 16'h0);
    set_lane(1, 1'b1, 32'h204, 5'd5, 5'd5, 1'b1, 32'h1234, 3'd0, 16'h0);
    set_fwd(2, 0, 5'd5, 32'h1, 1'b1);
    set_fwd(1, 1, 5'd5, 32'h7, 1'b0);
    set_fwd(0, 0, 5'd5, 32'h2, 1'b1);
    set_fwd(0, 1, 5'd5, 32'h3, 1'b1);
    exp_q.push_back(m_bundle());
    send();
    wait_valid();
    n_checks++; if (cyc - acc_cyc != 1) $display("FAIL prio_latency: got %0d want 1", cyc - acc_cyc); else n_pass++;
    n_checks++; if (bus.out_opa[31:0] !== 32'h3) $display("FAIL prio_opa0: got %h want 3", bus.out_opa[31:0]); else n_pass++;
    n_checks++; if (bus.out_opb[63:32] !== 32'h1234) $display("FAIL prio_imm: got %h want 1234", bus.out_opb[63:32]); else n_pass++;
  endtask

  task automatic test_load_hazard();
    @(posedge clk); #1;
    clear_inputs();
    rf[7] = 32'h11;
    set_lane(0, 1'b1, 32'h300, 5'd7, 5'd0, 1'b0, 32'h0, 3'd0, 16'h0);
    set_fwd(0, 0, 5'd7, 32'h0, 1'b0);
    send();
    repeat (3) begin @(posedge clk); #1; end
    set_fwd(0, 0, 5'd7, 32'hAB, 1'b1);
    exp_q.push_back(m_bundle());
    exp_stall += 3;
    wait_valid();
    n_checks++; if (cyc - acc_cyc != 4) $display("FAIL hazard_latency: got %0d want 4", cyc - acc_cyc); else n_pass++;
    n_checks++; if (bus.out_opa[31:0] !== 32'hAB) $display("FAIL hazard_opa: got %h want ab", bus.out_opa[31:0]); else n_pass++;
    n_checks++; if (bus.stall_cnt !== 16'(exp_stall)) $display("FAIL hazard_stall_cnt: got %0d want %0d", bus.stall_cnt, exp_stall); else n_pass++;
  endtask

  task automatic test_branches();
    @(posedge clk); #1;
    clear_inputs();
    rf[1] = 32'h0; rf[2] = 32'h80000000; rf[6] = 32'h7; rf[4] = 32'h4;
    set_lane(0, 1'b1, 32'h1000, 5'd1, 5'd6, 1'b0, 32'h0, 3'd3, 16'hFFFF);
    set_lane(1, 1'b1, 32'h2000, 5'd2, 5'd6, 1'b0, 32'h0, 3'd4, 16'h0003);
    exp_q.push_back(m_bundle());
    send();
    wait_valid();
    n_checks++; if (bus.out_br_taken !== 2'b01) $display("FAIL blez_bgtz_taken: got %b want 01", bus.out_br_taken); else n_pass++;
    n_checks++; if (bus.out_br_target[31:0] !== 32'h1000) $display("FAIL neg_off_target: got %h want 1000", bus.out_br_target[31:0]); else n_pass++;
    @(posedge clk); #1;
    set_lane(0, 1'b1, 32'h40, 5'd4, 5'd0, 1'b1, 32'h4, 3'd2, 16'h0);
    set_lane(1, 1'b1, 32'hFFFFFFF8, 5'd4, 5'd4, 1'b0, 32'h0, 3'd1, 16'h0001);
    exp_q.push_back(m_bundle());
    send();
    wait_valid();
    n_checks++; if (bus.out_br_taken !== 2'b10) $display("FAIL bne_beq_taken: got %b want 10", bus.out_br_taken); else n_pass++;
    n_checks++; if (bus.out_br_target[63:32] !== 32'h0) $display("FAIL wrap_target: got %h want 0", bus.out_br_target[63:32]); else n_pass++;
    @(posedge clk); #1;
    set_lane(0, 1'b1, 32'h80, 5'd2, 5'd0, 1'b0, 32'h0, 3'd5, 16'h0);
    set_lane(1, 1'b1, 32'h84, 5'd1, 5'd0, 1'b0, 32'h0, 3'd6, 16'h0);
    exp_q.push_back(m_bundle());
    send();
    wait_valid();
    n_checks++; if (bus.out_br_taken !== 2'b11) $display("FAIL bltz_bgez_taken: got %b want 11", bus.out_br_taken); else n_pass++;
  endtask

  task automatic test_random();
    for (int n = 0; n < 12; n++) begin
      @(posedge clk); #1;
      clear_inputs();
      for (int k = 1; k < 32; k++) rf[k] = $urandom;
      for (int l = 0; l < LANES; l++)
        set_lane(l, 1'($urandom_range(0, 1)), $urandom, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                 1'($urandom_range(0, 1)), $urandom, 3'($urandom_range(0, 7)), 16'($urandom));
      for (int st = 0; st < STAGES; st++)
        for (int ln = 0; ln < LANES; ln++)
          if ($urandom_range(0, 1) == 1) set_fwd(st, ln, 5'($urandom_range(0, 7)), $urandom, 1'b1);
      exp_q.push_back(m_bundle());
      send();
      wait_valid();
    end
  endtask

  task automatic test_back_to_back();
    @(posedge clk); #1;
    clear_inputs();
    bus.out_ready = 1'b0;
    rf[10] = 32'hCAFE0001; rf[11] = 32'hCAFE0002;
    set_lane(0, 1'b1, 32'h500, 5'd10, 5'd11, 1'b0, 32'h0, 3'd2, 16'h0010);
    set_lane(1, 1'b1, 32'h504, 5'd11, 5'd0, 1'b1, 32'h55, 3'd0, 16'h0);
    exp_q.push_back(m_bundle());
    send();
    wait_valid();
    for (int i = 0; i < 5; i++) begin
      n_checks++; if (bus.in_ready !== 1'b0) $display("FAIL bp_in_ready: got %b want 0", bus.in_ready); else n_pass++;
      n_checks++; if (obs() !== exp_q[0]) $display("FAIL bp_stable: got %h want %h", obs(), exp_q[0]); else n_pass++;
      @(negedge clk);
    end
    @(posedge clk); #1;
    rf[10] = 32'h12345678;
    set_lane(0, 1'b1, 32'h600, 5'd10, 5'd10, 1'b0, 32'h0, 3'd1, 16'h0002);
    set_lane(1, 1'b0, 32'h604, 5'd0, 5'd0, 1'b0, 32'h0, 3'd0, 16'h0);
    exp_q.push_back(m_bundle());
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1;
    @(negedge clk);
    n_checks++; if (bus.in_ready !== 1'b1) $display("FAIL handoff_in_ready: got %b want 1", bus.in_ready); else n_pass++;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    acc_cyc = cyc;
    wait_valid();
    n_checks++; if (cyc - acc_cyc != 1) $display("FAIL handoff_latency: got %0d want 1", cyc - acc_cyc); else n_pass++;
  endtask

  task automatic test_flush();
    @(posedge clk); #1;
    clear_inputs();
    set_lane(0, 1'b1, 32'h700, 5'd8, 5'd0, 1'b0, 32'h0, 3'd0, 16'h0);
    set_fwd(1, 1, 5'd8, 32'h0, 1'b0);
    send();
    repeat (2) begin @(posedge clk); #1; end
    exp_stall += 2;
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    @(negedge clk);
    n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL flush_stall_out_valid: got %b want 0", bus.out_valid); else n_pass++;
    n_checks++; if (bus.in_ready !== 1'b1) $display("FAIL flush_stall_empty: got %b want 1", bus.in_ready); else n_pass++;
    n_checks++; if (bus.stall_cnt !== 16'(exp_stall)) $display("FAIL flush_stall_cnt: got %0d want %0d", bus.stall_cnt, exp_stall); else n_pass++;
    @(posedge clk); #1;
    clear_inputs();
    set_lane(0, 1'b1, 32'h800, 5'd3, 5'd4, 1'b0, 32'h0, 3'd1, 16'h0);
    send();
    @(posedge clk); #1;
    bus.flush = 1'b1;
    bus.in_valid = 1'b1;
    @(negedge clk);
    n_checks++; if (bus.out_valid !== 1'b1) $display("FAIL flush_out_pre: got %b want 1", bus.out_valid); else n_pass++;
    n_checks++; if (bus.in_ready !== 1'b0) $display("FAIL flush_in_ready: got %b want 0", bus.in_ready); else n_pass++;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL flush_out_valid: got %b want 0", bus.out_valid); else n_pass++;
    n_checks++; if (bus.stall_cnt !== 16'(exp_stall)) $display("FAIL flush_out_stall_cnt: got %0d want %0d", bus.stall_cnt, exp_stall); else n_pass++;
  endtask

  task automatic test_reset_mid_stall();
    @(posedge clk); #1;
    clear_inputs();
    set_lane(1, 1'b1, 32'h900, 5'd12, 5'd0, 1'b0, 32'h0, 3'd0, 16'h0);
    set_fwd(2, 1, 5'd12, 32'h0, 1'b0);
    send();
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    exp_stall = 0;
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL rst_mid_out_valid: got %b want 0", bus.out_valid); else n_pass++;
    n_checks++; if (bus.in_ready !== 1'b1) $display("FAIL rst_mid_in_ready: got %b want 1", bus.in_ready); else n_pass++;
    n_checks++; if (obs() !== '0) $display("FAIL rst_mid_outputs: got %h want 0", obs()); else n_pass++;
    n_checks++; if (bus.stall_cnt !== 16'd0) $display("FAIL rst_mid_stall_cnt: got %0d want 0", bus.stall_cnt); else n_pass++;
    @(posedge clk); #1;
    rst_n = 1'b1;
    clear_inputs();
    repeat (3) @(negedge clk);
    n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL rst_mid_dropped: got %b want 0", bus.out_valid); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_r0_fwd();
    test_priority();
    test_load_hazard();
    test_branches();
    test_random();
    test_back_to_back();
    test_flush();
    test_reset_mid_stall();
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL queue_drained: got %0d pending want 0", exp_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end
endmodule
